// File: rtl/mem_arb.sv
// mem_arb: N-channel request arbiter in front of a single fixed-latency SRAM port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module mem_arb #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int MAX_OUT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_wr,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_wstrb,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    input  logic [NUM_CH-1:0]          ch_cancel,
    output logic [NUM_CH-1:0]          ch_addr_ok,
    output logic [NUM_CH-1:0]          ch_data_ok,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       mem_en,
    output logic [DATA_W/8-1:0]        mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);
    localparam int SW  = DATA_W / 8;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam int LS  = MEM_LAT - 1;

    logic [NUM_CH-1:0] elig;
    logic [CW-1:0]     out_cnt_q [NUM_CH];
    logic [CW-1:0]     out_cnt_d [NUM_CH];
    logic              gnt_vld;
    logic [CHW-1:0]    gnt_ch;
    logic [NUM_CH-1:0] gnt_oh;

    // Response tags travelling alongside the SRAM read pipeline.
    logic [MEM_LAT-1:0] tag_vld_q;
    logic [MEM_LAT-1:0] tag_vld_d;
    logic [MEM_LAT-1:0] tag_drop_q;
    logic [MEM_LAT-1:0] tag_drop_d;
    logic [CHW-1:0]     tag_ch_q [MEM_LAT];
    logic [CHW-1:0]     tag_ch_d [MEM_LAT];

    logic           ex_vld;
    logic [CHW-1:0] ex_ch;
    logic           ex_live;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_elig
            assign elig[gi] = ch_req[gi] & ~ch_cancel[gi] & ~rst
                            & (out_cnt_q[gi] != CW'(MAX_OUT));
        end
    endgenerate

`ifdef MEM_ARB_RR_EN
    logic [CHW-1:0] rr_q;
    logic [CHW-1:0] rr_d;

    // Scan from the furthest offset back to rr so the closest eligible channel wins.
    always_comb begin
        int             s;
        logic [CHW-1:0] idx;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        s       = 0;
        idx     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            s = int'(rr_q) + k;
            if (s >= NUM_CH) begin
                s = s - NUM_CH;
            end
            idx = CHW'(s);
            if (elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = idx;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_ch == CHW'(NUM_CH - 1)) ? '0 : gnt_ch + CHW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (elig[k]) begin
                gnt_vld = 1'b1;
                gnt_ch  = CHW'(k);
            end
        end
    end
`endif

    assign gnt_oh     = gnt_vld ? (NUM_CH'(1) << gnt_ch) : '0;
    assign ch_addr_ok = gnt_oh;

    // SRAM request mux; everything stays at zero when nothing is granted.
    always_comb begin
        mem_en    = gnt_vld;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_oh[i]) begin
                mem_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = ch_wdata[i*DATA_W +: DATA_W];
                mem_we    = ch_wr[i] ? ch_wstrb[i*SW +: SW] : '0;
            end
        end
    end

    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_vld_d[0]  = gnt_vld;
                assign tag_ch_d[0]   = gnt_ch;
                assign tag_drop_d[0] = 1'b0;
            end else begin : g_body
                // A cancel marks the tag as it moves, so it stays dropped to the end.
                assign tag_vld_d[gi]  = tag_vld_q[gi-1];
                assign tag_ch_d[gi]   = tag_ch_q[gi-1];
                assign tag_drop_d[gi] = tag_drop_q[gi-1] | ch_cancel[tag_ch_q[gi-1]];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q  <= '0;
            tag_drop_q <= '0;
            for (int s = 0; s < MEM_LAT; s++) begin
                tag_ch_q[s] <= '0;
            end
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_drop_q <= tag_drop_d;
            for (int s = 0; s < MEM_LAT; s++) begin
                tag_ch_q[s] <= tag_ch_d[s];
            end
        end
    end

    // A cancel arriving in the exit cycle still suppresses that response.
    assign ex_vld     = tag_vld_q[LS];
    assign ex_ch      = tag_ch_q[LS];
    assign ex_live    = ex_vld & ~tag_drop_q[LS] & ~ch_cancel[ex_ch] & ~rst;
    assign ch_data_ok = ex_live ? (NUM_CH'(1) << ex_ch) : '0;
    assign ch_rdata   = mem_rdata;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            logic inc;
            logic dec;

            assign inc = gnt_oh[gi];
            assign dec = ex_vld & (ex_ch == CHW'(gi));

            always_comb begin
                out_cnt_d[gi] = out_cnt_q[gi];
                if (inc && !dec) begin
                    out_cnt_d[gi] = out_cnt_q[gi] + CW'(1);
                end else if (dec && !inc) begin
                    out_cnt_d[gi] = out_cnt_q[gi] - CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_cnt_q[gi] <= '0;
                end else begin
                    out_cnt_q[gi] <= out_cnt_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with 2 channels, MEM_LAT=2, MAX_OUT=2 and a small SRAM model.
`timescale 1ns/1ps
module tb_mem_arb;
    localparam int NUM_CH  = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_req, ch_wr, ch_cancel;
    logic [7:0]  ch_wstrb;
    logic [63:0] ch_addr, ch_wdata;
    logic [1:0]  ch_addr_ok, ch_data_ok;
    logic [31:0] ch_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sram [256];
    logic [31:0] rd0, rd1;
    int          exp_g [6];
    int          acc3 [6];

    always #5 clk = ~clk;

    mem_arb #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MEM_LAT(MEM_LAT), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_wstrb(ch_wstrb),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_cancel(ch_cancel),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // SRAM model: word index addr[9:2], read-before-write, two-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            sram[8'h00] <= 32'hDEADBEEF;
            sram[8'h40] <= 32'hAAAAAAAA;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) sram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
        rd0 <= mem_en ? sram[mem_addr[9:2]] : 32'h0;
        rd1 <= rd0;
    end
    assign mem_rdata = rd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int g);
        logic [1:0] one;
        one = 2'b01;
        return one << g;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1, 0, 1};
`else
        exp_g = '{0, 0, 1, 0, 0, 1};
`endif
        acc3 = '{1, 1, 0, 1, 1, 0};

        rst = 1'b1; ch_req = 2'b11; ch_wr = 2'b00; ch_cancel = 2'b00;
        ch_wstrb = 8'h0; ch_addr = {32'h0000_0044, 32'h0000_0040}; ch_wdata = 64'h0;
        next_cycle();
        @(negedge clk);
        chk("rst_addr_ok", 32'(ch_addr_ok), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_data_ok", 32'(ch_data_ok), 32'h0);
        next_cycle();
        rst = 1'b0;

        // Both channels request for six cycles, then drain.
        for (int c = 0; c < 8; c++) begin
            ch_req = (c < 6) ? 2'b11 : 2'b00;
            @(negedge clk);
            chk($sformatf("arb_addr_ok_c%0d", c), 32'(ch_addr_ok), (c < 6) ? 32'(oh(exp_g[c])) : 32'h0);
            if (c < 6)
                chk($sformatf("arb_mem_addr_c%0d", c), mem_addr, (exp_g[c] == 1) ? 32'h44 : 32'h40);
            chk($sformatf("arb_data_ok_c%0d", c), 32'(ch_data_ok), (c >= 2) ? 32'(oh(exp_g[c-2])) : 32'h0);
            next_cycle();
        end

        // Outstanding limit on ch1; addr_ok stays low in the tag-exit cycle.
        for (int c = 0; c < 8; c++) begin
            ch_req = (c < 6) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk($sformatf("lim_addr_ok_c%0d", c), 32'(ch_addr_ok), (c < 6 && acc3[c] == 1) ? 32'h2 : 32'h0);
            chk($sformatf("lim_data_ok_c%0d", c), 32'(ch_data_ok), (c >= 2 && acc3[c-2] == 1) ? 32'h2 : 32'h0);
            next_cycle();
        end

        // Single read from ch0.
        ch_req = 2'b01; ch_addr[31:0] = 32'h1C00_0000;
        @(negedge clk);
        chk("rd_addr_ok", 32'(ch_addr_ok), 32'h1);
        chk("rd_mem_addr", mem_addr, 32'h1C00_0000);
        chk("rd_mem_we", 32'(mem_we), 32'h0);
        next_cycle();
        ch_req = 2'b00;
        @(negedge clk);
        chk("rd_data_ok_t1", 32'(ch_data_ok), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rd_data_ok_t2", 32'(ch_data_ok), 32'h1);
        chk("rd_rdata", ch_rdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        chk("rd_data_ok_t3", 32'(ch_data_ok), 32'h0);
        next_cycle();

        // Partial write then read back.
        ch_req = 2'b01; ch_wr = 2'b01; ch_addr[31:0] = 32'h100;
        ch_wdata[31:0] = 32'h1234_5678; ch_wstrb[3:0] = 4'b0011;
        @(negedge clk);
        chk("wr_addr_ok", 32'(ch_addr_ok), 32'h1);
        chk("wr_mem_we", 32'(mem_we), 32'h3);
        chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        next_cycle();
        ch_wr = 2'b00;
        @(negedge clk);
        chk("wr_rd_addr_ok", 32'(ch_addr_ok), 32'h1);
        chk("wr_rd_mem_we", 32'(mem_we), 32'h0);
        next_cycle();
        ch_req = 2'b00;
        @(negedge clk);
        chk("wr_data_ok", 32'(ch_data_ok), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("wr_rd_data_ok", 32'(ch_data_ok), 32'h1);
        chk("wr_rd_rdata", ch_rdata, 32'hAAAA_5678);
        next_cycle();

        // Cancel drops both in-flight ch0 responses, including the exiting one.
        ch_req = 2'b01; ch_addr[31:0] = 32'h1C00_0000;
        @(negedge clk);
        chk("cx_acc_t0", 32'(ch_addr_ok), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("cx_acc_t1", 32'(ch_addr_ok), 32'h1);
        next_cycle();
        ch_cancel = 2'b01;
        @(negedge clk);
        chk("cx_addr_ok_t2", 32'(ch_addr_ok), 32'h0);
        chk("cx_data_ok_t2", 32'(ch_data_ok), 32'h0);
        next_cycle();
        ch_cancel = 2'b00; ch_req = 2'b00;
        @(negedge clk);
        chk("cx_data_ok_t3", 32'(ch_data_ok), 32'h0);
        next_cycle();
        ch_req = 2'b01;
        @(negedge clk);
        chk("cx_reacc_t4", 32'(ch_addr_ok), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("cx_reacc_t5", 32'(ch_addr_ok), 32'h1);
        next_cycle();
        ch_req = 2'b00;
        @(negedge clk);
        chk("cx_data_ok_t6", 32'(ch_data_ok), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("cx_data_ok_t7", 32'(ch_data_ok), 32'h1);
        next_cycle();

        // Reset one cycle after an accepted read discards the response.
        ch_req = 2'b01;
        @(negedge clk);
        chk("mr_acc", 32'(ch_addr_ok), 32'h1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_rst_addr_ok", 32'(ch_addr_ok), 32'h0);
        chk("mr_rst_data_ok", 32'(ch_data_ok), 32'h0);
        next_cycle();
        rst = 1'b0; ch_req = 2'b00;
        @(negedge clk);
        chk("mr_data_ok_t2", 32'(ch_data_ok), 32'h0);
        next_cycle();
        ch_req = 2'b10; ch_addr[63:32] = 32'h1C00_0000;
        @(negedge clk);
        chk("mr_new_acc", 32'(ch_addr_ok), 32'h2);
        next_cycle();
        ch_req = 2'b00;
        @(negedge clk);
        chk("mr_new_data_ok_t1", 32'(ch_data_ok), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("mr_new_data_ok_t2", 32'(ch_data_ok), 32'h2);
        chk("mr_new_rdata", ch_rdata, 32'hDEADBEEF);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
